// File: rtl/systolic_pkg.sv
// systolic_pkg: shared FSM state type and sizing helpers for the systolic feeder.
package systolic_pkg;

    typedef enum logic [2:0] {IDLE, WFILL, WPUSH, STREAM, DRAIN} state_t;

    function automatic int drain_cycles(input int rows, input int cols, input int skew);
        return (rows + cols - 1) * skew;
    endfunction

    function automatic int lane_lo(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/systolic_skew_line.sv
// systolic_skew_line: DEPTH-stage enabled delay line; DEPTH of zero is a plain wire.
module systolic_skew_line #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    generate
        if (DEPTH == 0) begin : g_pass
            logic unused_ctl;
            assign unused_ctl = ^{clk, reset, en};
            assign q = d;
        end else begin : g_sr
            logic [WIDTH-1:0] sr [DEPTH];
            always_ff @(posedge clk or negedge reset)
                if (!reset) begin
                    for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
                end else if (en) begin
                    sr[0] <= d;
                    for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
                end
            assign q = sr[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/systolic_feeder.sv
// systolic_feeder: loads a weight tile down the PE columns, then streams row-skewed activations and flushes.
module systolic_feeder
    import systolic_pkg::*;
#(
    parameter int ROWS      = 4,
    parameter int COLS      = 4,
    parameter int DATA_SIZE = 32,
    parameter int SKEW      = 4,
    parameter int MAX_K     = 256,
    localparam int KW       = $clog2(MAX_K + 1)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      cfg_start,
    input  logic [KW-1:0]             cfg_k,
    output logic                      busy,
    output logic                      done,
    input  logic                      w_valid,
    output logic                      w_ready,
    input  logic [COLS*DATA_SIZE-1:0] w_data,
    input  logic                      a_valid,
    output logic                      a_ready,
    input  logic [ROWS*DATA_SIZE-1:0] a_data,
    output logic [ROWS-1:0]           pe_enable,
    output logic [ROWS-1:0]           pe_ld_weight,
    output logic [ROWS*DATA_SIZE-1:0] pe_in_data,
    output logic [COLS*DATA_SIZE-1:0] pe_in_sum
);

    localparam int DRAIN_N = drain_cycles(ROWS, COLS, SKEW);
    localparam int CW      = $clog2(ROWS + 1);
    localparam int DW      = $clog2(DRAIN_N + 1);

    state_t                     state, state_n;
    logic [CW-1:0]              cnt, cnt_n;
    logic [KW-1:0]              k_reg, k_n, kcnt, kcnt_n;
    logic [DW-1:0]              dcnt, dcnt_n;
    logic [COLS*DATA_SIZE-1:0]  stack [ROWS];
    logic [COLS*DATA_SIZE-1:0]  sum_n;
    logic [ROWS*DATA_SIZE-1:0]  line_q;
    logic                       w_hs, a_hs, shift;

    assign w_hs  = w_valid && w_ready;
    assign a_hs  = a_valid && a_ready;
    assign shift = state inside {STREAM, DRAIN};

    // cnt counts weight beats up during fill and pops down during push
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        k_n     = k_reg;
        kcnt_n  = kcnt;
        dcnt_n  = dcnt;
        sum_n   = '0;
        case (state)
            IDLE: if (cfg_start) begin
                state_n = WFILL;
                k_n     = cfg_k;
                cnt_n   = '0;
                kcnt_n  = '0;
            end
            WFILL: if (w_hs) begin
                cnt_n = cnt + 1'b1;
                if (cnt == CW'(ROWS - 1)) begin
                    state_n = WPUSH;
                    sum_n   = w_data;
                end
            end
            WPUSH: begin
                cnt_n = cnt - 1'b1;
                if (cnt == CW'(1)) begin
                    state_n = (k_reg == '0) ? DRAIN : STREAM;
                    dcnt_n  = DW'(DRAIN_N - 1);
                end else begin
                    sum_n = stack[1];
                end
            end
            STREAM: if (a_hs) begin
                kcnt_n = kcnt + 1'b1;
                if (kcnt_n == k_reg) begin
                    state_n = DRAIN;
                    dcnt_n  = DW'(DRAIN_N - 1);
                end
            end
            DRAIN: begin
                state_n = (dcnt == '0) ? IDLE : DRAIN;
                dcnt_n  = (dcnt == '0) ? dcnt : dcnt - 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state        <= IDLE;
            cnt          <= '0;
            k_reg        <= '0;
            kcnt         <= '0;
            dcnt         <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            w_ready      <= 1'b0;
            a_ready      <= 1'b0;
            pe_enable    <= '0;
            pe_ld_weight <= '0;
            pe_in_sum    <= '0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            k_reg        <= k_n;
            kcnt         <= kcnt_n;
            dcnt         <= dcnt_n;
            busy         <= state_n != IDLE;
            done         <= state_n == DRAIN && dcnt_n == '0;
            w_ready      <= state_n == WFILL;
            a_ready      <= state_n == STREAM;
            pe_enable    <= {ROWS{state_n inside {WPUSH, STREAM, DRAIN}}};
            pe_ld_weight <= {ROWS{state_n == WPUSH}};
            pe_in_sum    <= sum_n;
        end

    // Stack with top at index 0: the last row written is the first row pushed out
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            for (int i = 0; i < ROWS; i++) stack[i] <= '0;
        end else if (w_hs) begin
            stack[0] <= w_data;
            for (int i = 1; i < ROWS; i++) stack[i] <= stack[i-1];
        end else if (state == WPUSH) begin
            for (int i = 0; i < ROWS - 1; i++) stack[i] <= stack[i+1];
            stack[ROWS-1] <= '0;
        end

    generate
        for (genvar r = 0; r < ROWS; r++) begin : g_row
            systolic_skew_line #(
                .DEPTH (r * SKEW),
                .WIDTH (DATA_SIZE)
            ) u_line (
                .clk   (clk),
                .reset (reset),
                .en    (shift),
                .d     (a_hs ? a_data[lane_lo(r, DATA_SIZE) +: DATA_SIZE] : '0),
                .q     (line_q[lane_lo(r, DATA_SIZE) +: DATA_SIZE])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge reset)
        if (!reset) pe_in_data <= '0;
        else if (shift) pe_in_data <= line_q;

endmodule

// File: tb/tb_systolic_feeder.sv
// tb_systolic_feeder: randomized scenarios checked against an injection-history model of the feeder.
module tb_systolic_feeder;

    localparam int ROWS    = 2;
    localparam int COLS    = 2;
    localparam int DS      = 32;
    localparam int SKEW    = 4;
    localparam int MAX_K   = 256;
    localparam int KW      = $clog2(MAX_K + 1);
    localparam int DRAIN_N = (ROWS + COLS - 1) * SKEW;

    logic                 clk = 1'b0;
    logic                 reset = 1'b0;
    logic                 cfg_start = 1'b0;
    logic [KW-1:0]        cfg_k = '0;
    logic                 busy, done, w_ready, a_ready;
    logic                 w_valid = 1'b0;
    logic [COLS*DS-1:0]   w_data = '0;
    logic                 a_valid = 1'b0;
    logic [ROWS*DS-1:0]   a_data = '0;
    logic [ROWS-1:0]      pe_enable, pe_ld_weight;
    logic [ROWS*DS-1:0]   pe_in_data;
    logic [COLS*DS-1:0]   pe_in_sum;

    int n_vec = 0;
    int n_err = 0;

    logic [ROWS*DS-1:0] vecs[$];
    logic [ROWS*DS-1:0] inj[$];
    logic [COLS*DS-1:0] w_rows [ROWS];

    systolic_feeder #(
        .ROWS(ROWS), .COLS(COLS), .DATA_SIZE(DS), .SKEW(SKEW), .MAX_K(MAX_K)
    ) dut (
        .clk(clk), .reset(reset), .cfg_start(cfg_start), .cfg_k(cfg_k),
        .busy(busy), .done(done),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
        .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
        .pe_enable(pe_enable), .pe_ld_weight(pe_ld_weight),
        .pe_in_data(pe_in_data), .pe_in_sum(pe_in_sum)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_weights();
        for (int i = 0; i < ROWS; i++) w_rows[i] = {$urandom, $urandom};
    endtask

    task automatic rand_vecs(input int k);
        vecs.delete();
        for (int i = 0; i < k; i++) vecs.push_back({$urandom, $urandom});
    endtask

    // Full job: start, weight fill with gaps, push, stream (optional bubbles), drain.
    // Expected lane data comes from the injection history: row r shows inj[j - r*SKEW].
    task automatic run_job(input int k, input int gap_lo, input int gap_hi,
                           input int bubble_at, input int bubble_pct, input bit noise);
        int got, d, step, gaps, idx;
        bit bubble, hs;
        logic [ROWS*DS-1:0] v;
        logic [DS-1:0] e, o;
        inj.delete();
        cfg_k = KW'(k);
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        n_vec++;
        if (busy !== 1'b1 || w_ready !== 1'b1 || pe_enable !== '0)
            begin n_err++; $display("FAIL start: busy=%b w_ready=%b en=%b want 1 1 00", busy, w_ready, pe_enable); end
        for (int i = 0; i < ROWS; i++) begin
            gaps = $urandom_range(gap_lo, gap_hi);
            for (int g = 0; g < gaps; g++) begin
                w_valid = 1'b0;
                w_data = {$urandom, $urandom};
                cfg_start = noise;
                cfg_k = KW'($urandom_range(0, MAX_K));
                a_valid = noise;
                a_data = {$urandom, $urandom};
                tick();
                n_vec++;
                if (w_ready !== 1'b1 || busy !== 1'b1 || pe_ld_weight !== '0 || pe_in_data !== '0)
                    begin n_err++; $display("FAIL wfill_gap: w_ready=%b busy=%b ld=%b data=%h want 1 1 00 0", w_ready, busy, pe_ld_weight, pe_in_data); end
            end
            cfg_start = 1'b0;
            w_valid = 1'b1;
            w_data = w_rows[i];
            tick();
            w_valid = 1'b0;
        end
        for (int c = 0; c <= ROWS; c++) begin
            n_vec++;
            if (c < ROWS) begin
                if (pe_ld_weight !== 2'b11 || pe_enable !== 2'b11 || w_ready !== 1'b0 || pe_in_sum !== w_rows[ROWS-1-c])
                    begin n_err++; $display("FAIL wpush[%0d]: ld=%b en=%b w_ready=%b sum=%h want ld=11 en=11 w_ready=0 sum=%h", c, pe_ld_weight, pe_enable, w_ready, pe_in_sum, w_rows[ROWS-1-c]); end
                w_valid = noise;
                w_data = {$urandom, $urandom};
                a_valid = noise;
                a_data = {$urandom, $urandom};
                tick();
            end else if (pe_ld_weight !== '0 || pe_in_sum !== '0) begin
                n_err++; $display("FAIL wpush_end: ld=%b sum=%h want 00 0", pe_ld_weight, pe_in_sum);
            end
        end
        got = 0;
        d = (k == 0) ? 0 : -1;
        step = 0;
        while (1) begin
            if (d < 0) begin
                n_vec++;
                if (a_ready !== 1'b1)
                    begin n_err++; $display("FAIL stream_ready step %0d: a_ready=%b want 1", step, a_ready); end
                bubble = (step == bubble_at) || ($urandom_range(0, 99) < bubble_pct);
                a_valid = !bubble;
                a_data = bubble ? {$urandom, $urandom} : vecs[got];
            end else begin
                n_vec++;
                if (done !== (d == DRAIN_N - 1) || busy !== (d < DRAIN_N) || a_ready !== 1'b0)
                    begin n_err++; $display("FAIL drain d=%0d: done=%b busy=%b a_ready=%b want %b %b 0", d, done, busy, a_ready, d == DRAIN_N - 1, d < DRAIN_N); end
                if (d == DRAIN_N) break;
                bubble = 1'b1;
                a_valid = noise;
                a_data = {$urandom, $urandom};
            end
            hs = (d < 0) && !bubble;
            w_valid = noise;
            w_data = {$urandom, $urandom};
            tick();
            inj.push_back(hs ? vecs[got] : '0);
            if (d >= 0) d++;
            else if (hs) begin
                got++;
                if (got == k) d = 0;
            end
            step++;
            for (int r = 0; r < ROWS; r++) begin
                idx = inj.size() - 1 - r * SKEW;
                v = (idx >= 0) ? inj[idx] : '0;
                e = v[r*DS +: DS];
                o = pe_in_data[r*DS +: DS];
                n_vec++;
                if (o !== e)
                    begin n_err++; $display("FAIL lane%0d step %0d: got %h want %h", r, step, o, e); end
            end
            n_vec++;
            if (pe_ld_weight !== '0 || pe_in_sum !== '0)
                begin n_err++; $display("FAIL stream_sum step %0d: ld=%b sum=%h want 00 0", step, pe_ld_weight, pe_in_sum); end
            if (step > 1000) begin
                n_err++;
                $display("FAIL timeout: job k=%0d stuck after %0d steps", k, step);
                break;
            end
        end
        a_valid = 1'b0;
        w_valid = 1'b0;
        cfg_start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        tick();
        n_vec++;
        if ({busy, done, w_ready, a_ready, pe_enable, pe_ld_weight} !== '0 || pe_in_data !== '0 || pe_in_sum !== '0)
            begin n_err++; $display("FAIL reset: busy=%b done=%b wr=%b ar=%b en=%b ld=%b data=%h sum=%h want all 0", busy, done, w_ready, a_ready, pe_enable, pe_ld_weight, pe_in_data, pe_in_sum); end
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            w_valid = 1'b1;
            w_data = {$urandom, $urandom};
            a_valid = 1'b1;
            a_data = {$urandom, $urandom};
            tick();
            n_vec++;
            if ({busy, done, w_ready, a_ready, pe_enable, pe_ld_weight} !== '0 || pe_in_data !== '0 || pe_in_sum !== '0)
                begin n_err++; $display("FAIL idle[%0d]: busy=%b done=%b wr=%b ar=%b en=%b ld=%b data=%h sum=%h want all 0", i, busy, done, w_ready, a_ready, pe_enable, pe_ld_weight, pe_in_data, pe_in_sum); end
        end
        w_valid = 1'b0;
        a_valid = 1'b0;
    endtask

    task automatic test_weights();
        w_rows[0] = {32'd2, 32'd1};
        w_rows[1] = {32'd4, 32'd3};
        rand_vecs(1);
        run_job(1, 1, 3, -1, 0, 1'b1);
    endtask

    task automatic test_back_to_back();
        rand_weights();
        vecs.delete();
        vecs.push_back({32'd20, 32'd10});
        vecs.push_back({32'd21, 32'd11});
        vecs.push_back({32'd22, 32'd12});
        run_job(3, 0, 0, -1, 0, 1'b0);
    endtask

    task automatic test_bubble();
        rand_weights();
        rand_vecs(2);
        run_job(2, 0, 1, 1, 0, 1'b0);
    endtask

    task automatic test_k0();
        rand_weights();
        vecs.delete();
        run_job(0, 0, 2, -1, 0, 1'b1);
    endtask

    task automatic test_reset_midrun();
        cfg_k = KW'(5);
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        for (int i = 0; i < ROWS; i++) begin
            w_valid = 1'b1;
            w_data = {$urandom, $urandom};
            tick();
        end
        w_valid = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 3; i++) begin
            a_valid = 1'b1;
            a_data = {$urandom | 32'h1, $urandom | 32'h1};
            tick();
        end
        n_vec++;
        if (a_ready !== 1'b1 || pe_in_data[DS-1:0] === '0)
            begin n_err++; $display("FAIL midrun_stream: a_ready=%b lane0=%h want 1 nonzero", a_ready, pe_in_data[DS-1:0]); end
        #2 reset = 1'b0;
        #1;
        n_vec++;
        if ({busy, done, w_ready, a_ready, pe_enable, pe_ld_weight} !== '0 || pe_in_data !== '0 || pe_in_sum !== '0)
            begin n_err++; $display("FAIL async_reset: busy=%b done=%b wr=%b ar=%b en=%b ld=%b data=%h want all 0", busy, done, w_ready, a_ready, pe_enable, pe_ld_weight, pe_in_data); end
        a_valid = 1'b0;
        tick();
        n_vec++;
        if (busy !== 1'b0 || done !== 1'b0)
            begin n_err++; $display("FAIL reset_hold: busy=%b done=%b want 0 0", busy, done); end
        reset = 1'b1;
        tick();
        rand_weights();
        rand_vecs(3);
        run_job(3, 0, 1, -1, 20, 1'b0);
    endtask

    task automatic test_random();
        int k;
        for (int n = 0; n < 4; n++) begin
            k = $urandom_range(1, 8);
            rand_weights();
            rand_vecs(k);
            run_job(k, 0, 2, -1, 30, 1'b1);
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_weights();
        test_back_to_back();
        test_bubble();
        test_k0();
        test_reset_midrun();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
